// File: rtl/dec_sel_pkg.sv
// Shared types and widths for the dec_sel_arb round-robin decoder-select arbiter.
package dec_sel_pkg;

    localparam int N_REQ  = 4;
    localparam int IDX_W  = 2;
    localparam int GAP_W  = 4;   // holds GAP_CYCLES-1, GAP_CYCLES up to 15
    localparam int HOLD_W = 8;   // holds MAX_HOLD, up to 255

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set req bit scanning upward from (last+1) mod N_REQ.
module rr_pick
    import dec_sel_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        any  = |req;
        idx  = '0;
        cand = '0;
        // Walk from farthest to nearest so the nearest set bit after last wins.
        for (int i = N_REQ; i >= 1; i--) begin
            cand = last + IDX_W'(i);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/dec_sel_arb.sv
// Round-robin arbiter driving a 2-to-4 active-low decoder (en, a) with break-before-make gaps.
// Optional grant-length limit enabled by defining DEC_SEL_HOLD_LIMIT_EN.
module dec_sel_arb
    import dec_sel_pkg::*;
#(
    parameter int GAP_CYCLES = 1
`ifdef DEC_SEL_HOLD_LIMIT_EN
    ,
    parameter int MAX_HOLD = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic             en,
    output logic [IDX_W-1:0] a,
    output logic             hold_expired
);

    state_t           state;
    logic [IDX_W-1:0] last;
    logic [GAP_W-1:0] gap_cnt;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             drop_now;
    logic             expire_now;

    rr_pick u_pick (
        .req  (req),
        .last (last),
        .any  (pick_any),
        .idx  (pick_idx)
    );

`ifdef DEC_SEL_HOLD_LIMIT_EN
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
    logic [HOLD_W-1:0] hold_cnt;

    always_comb begin
        drop_now   = ~req[a];
        expire_now = req[a] && (hold_cnt == HOLD_LIM);
    end
`else
    always_comb begin
        drop_now   = ~req[a];
        expire_now = 1'b0;
    end

    assign hold_expired = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            en      <= 1'b0;
            a       <= '0;
            last    <= IDX_W'(N_REQ - 1);
            gap_cnt <= '0;
`ifdef DEC_SEL_HOLD_LIMIT_EN
            hold_cnt     <= '0;
            hold_expired <= 1'b0;
`endif
        end else begin
`ifdef DEC_SEL_HOLD_LIMIT_EN
            hold_expired <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        en    <= 1'b1;
                        a     <= pick_idx;
                        state <= GRANT;
`ifdef DEC_SEL_HOLD_LIMIT_EN
                        hold_cnt <= HOLD_W'(1);
`endif
                    end
                end
                GRANT: begin
                    // A forced expiry ends the grant exactly like a release.
                    if (drop_now || expire_now) begin
                        en      <= 1'b0;
                        last    <= a;
                        gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                        state   <= GAP;
`ifdef DEC_SEL_HOLD_LIMIT_EN
                        hold_expired <= expire_now;
`endif
                    end
`ifdef DEC_SEL_HOLD_LIMIT_EN
                    else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
`endif
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dec_sel_arb.sv
// Table-driven bench for dec_sel_arb (GAP_CYCLES=1, MAX_HOLD=4 when DEC_SEL_HOLD_LIMIT_EN is set).
module tb_dec_sel_arb;

    typedef struct {
        logic [3:0] req;
        logic       en;
        logic [1:0] a;
        logic       hx;
    } vec_t;

    typedef struct {
        logic [3:0] req;
        logic [1:0] last;
        logic       any;
        logic [1:0] idx;
    } pick_vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       en;
    logic [1:0] a;
    logic       hold_expired;

    logic [3:0] p_req  = 4'b0000;
    logic [1:0] p_last = 2'b00;
    logic       p_any;
    logic [1:0] p_idx;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    dec_sel_arb #(
        .GAP_CYCLES (1)
`ifdef DEC_SEL_HOLD_LIMIT_EN
        ,
        .MAX_HOLD   (4)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .en           (en),
        .a            (a),
        .hold_expired (hold_expired)
    );

    rr_pick u_pick (
        .req  (p_req),
        .last (p_last),
        .any  (p_any),
        .idx  (p_idx)
    );

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic e, input logic [1:0] s, input logic h);
        vec_t v;
        v.req = r;
        v.en  = e;
        v.a   = s;
        v.hx  = h;
        vq.push_back(v);
    endtask

    // Each row: drive req for one cycle, then compare outputs after the next rising edge.
    task automatic run_queue(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            req = vq[i].req;
            @(negedge clk);
            check($sformatf("%s[%0d].en", tag, i), 8'(en), 8'(vq[i].en));
            if (vq[i].en) check($sformatf("%s[%0d].a", tag, i), 8'(a), 8'(vq[i].a));
            check($sformatf("%s[%0d].hx", tag, i), 8'(hold_expired), 8'(vq[i].hx));
        end
        vq.delete();
    endtask

    task automatic check_outs(input string tag, input logic e, input logic [1:0] s, input logic h);
        check({tag, ".en"}, 8'(en), 8'(e));
        check({tag, ".a"}, 8'(a), 8'(s));
        check({tag, ".hx"}, 8'(hold_expired), 8'(h));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        #1;
        check_outs("reset", 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        pick_vec_t pv[7];

        // Stand-alone pick unit
        pv[0] = '{4'b0000, 2'd2, 1'b0, 2'd0};
        pv[1] = '{4'b1111, 2'd3, 1'b1, 2'd0};
        pv[2] = '{4'b1111, 2'd1, 1'b1, 2'd2};
        pv[3] = '{4'b0001, 2'd0, 1'b1, 2'd0};
        pv[4] = '{4'b1010, 2'd1, 1'b1, 2'd3};
        pv[5] = '{4'b0110, 2'd2, 1'b1, 2'd1};
        pv[6] = '{4'b1001, 2'd3, 1'b1, 2'd0};
        for (int i = 0; i < 7; i++) begin
            p_req  = pv[i].req;
            p_last = pv[i].last;
            #1;
            check($sformatf("pick[%0d].any", i), 8'(p_any), 8'(pv[i].any));
            if (pv[i].any) check($sformatf("pick[%0d].idx", i), 8'(p_idx), 8'(pv[i].idx));
        end

        // Reset state, then idle with no requests
        #2;
        check_outs("reset_hold", en, 2'b00, 1'b0);
        check("reset_en", 8'(en), 8'h00);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) add(4'b0000, 1'b0, 2'b00, 1'b0);
        run_queue("idle");
        check("idle.a", 8'(a), 8'h00);

        // Single grant to 2, gap, late request granted at cycle 7, one-cycle grant
        for (int i = 0; i < 4; i++) add(4'b0100, 1'b1, 2'd2, 1'b0);
        add(4'b0000, 1'b0, 2'd2, 1'b0);
        add(4'b0001, 1'b0, 2'd2, 1'b0);
        add(4'b0001, 1'b1, 2'd0, 1'b0);
        add(4'b0000, 1'b0, 2'd0, 1'b0);
        add(4'b0000, 1'b0, 2'd0, 1'b0);
        run_queue("single");
        check("single.a_kept", 8'(a), 8'h00);

        // Rotation with all four requesting; each owner drops its bit for the gap
        do_reset();
        for (int k = 0; k < 4; k++) begin
            logic [3:0] drop;
            drop = 4'b1111 & ~(4'b0001 << k);
            for (int i = 0; i < 3; i++) add(4'b1111, 1'b1, 2'(k), 1'b0);
            add(drop, 1'b0, 2'(k), 1'b0);
            add(drop, 1'b0, 2'(k), 1'b0);
        end
        add(4'b1111, 1'b1, 2'd0, 1'b0);
        add(4'b0000, 1'b0, 2'd0, 1'b0);
        add(4'b0000, 1'b0, 2'd0, 1'b0);
        run_queue("rotate");
        check("rotate.a_last", 8'(a), 8'h00);

        // Asynchronous reset mid-grant, then pointer back to 3
        add(4'b1000, 1'b1, 2'd3, 1'b0);
        add(4'b1000, 1'b1, 2'd3, 1'b0);
        run_queue("pre_rst");
        #2;
        rst = 1'b1;
        req = 4'b1001;
        #1;
        check_outs("async_rst", 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outs("post_rst", 1'b1, 2'b00, 1'b0);
        add(4'b0000, 1'b0, 2'd0, 1'b0);
        add(4'b0000, 1'b0, 2'd0, 1'b0);
        run_queue("post_rst_drop");

        // Long grant to requester 1
        for (int i = 0; i < 4; i++) add(4'b0010, 1'b1, 2'd1, 1'b0);
`ifdef DEC_SEL_HOLD_LIMIT_EN
        add(4'b0010, 1'b0, 2'd1, 1'b1);
        add(4'b0010, 1'b0, 2'd1, 1'b0);
        add(4'b0010, 1'b1, 2'd1, 1'b0);
        add(4'b0010, 1'b1, 2'd1, 1'b0);
`else
        for (int i = 0; i < 16; i++) add(4'b0010, 1'b1, 2'd1, 1'b0);
`endif
        run_queue("hold");
        add(4'b0000, 1'b0, 2'd1, 1'b0);
        add(4'b0000, 1'b0, 2'd1, 1'b0);
        run_queue("hold_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
